uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The parameter OVS_DIV SHALL default to 325 and SHALL be the number of clk cycles per 16x-oversample tick (50 MHz, 9600 baud).
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the system clock; all state SHALL update on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, asynchronous, active-high reset.
REQ-004 The port uart_rx SHALL be an input, 1 bit wide, carrying the serial line (idle high, 8N1, LSB first).
REQ-005 The port rd SHALL be an input, 1 bit wide, asserted for one cycle when the consumer has taken rx_data.
REQ-006 The port rx_data SHALL be an output, 8 bits wide, holding the last good received byte.
REQ-007 The port rx_ready SHALL be an output, 1 bit wide, high while an unread byte is held in rx_data.
REQ-008 The port overrun SHALL be an output, 1 bit wide, a sticky flag set when a byte arrives while rx_ready is high.
REQ-009 The port frame_err SHALL be an output, 1 bit wide, a sticky flag set when a stop bit samples low.
REQ-010 The port rx_busy SHALL be an output, 1 bit wide, high whenever the FSM is not in IDLE.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all sampling SHALL use the second flop (rxs).
REQ-012 A free-running divider SHALL count 0..OVS_DIV-1, wrap to 0, and assert tick for the one cycle in which it equals OVS_DIV-1.
REQ-013 The FSM SHALL have the states IDLE, START, DATA and STOP; a 4-bit tick counter and a 3-bit bit index SHALL advance only on tick.
REQ-014 In IDLE, on a tick with rxs=0, the FSM SHALL go to START with the tick counter at 0.
REQ-015 In START, on the 8th tick (mid-bit), the FSM SHALL go to DATA with the counters cleared if rxs=0, else return to IDLE (glitch rejected, no flags set).
REQ-016 In DATA, every 16th tick SHALL shift rxs into bit[index] (LSB first); after index 7 the FSM SHALL go to STOP.
REQ-017 In STOP, on the 16th tick, with rxs=1: rx_data SHALL load the shift register and rx_ready SHALL be set; overrun SHALL also be set if rx_ready was already 1 and rd is not asserted that cycle.
REQ-018 In STOP, on the 16th tick, with rxs=0: frame_err SHALL be set and rx_data/rx_ready SHALL remain unchanged.
REQ-019 After STOP the FSM SHALL return to IDLE and SHALL be able to detect a new start bit on the next tick.
REQ-020 rd SHALL clear rx_ready, overrun and frame_err on the following edge, unless a byte load occurs in the same cycle.
REQ-021 If rd and a byte load coincide, the load SHALL win: rx_ready=1, rx_data=new byte, overrun unchanged, frame_err cleared.
REQ-022 rd while rx_ready=0 SHALL have no effect other than clearing the flags.
REQ-023 rx_ready SHALL rise on the clk edge immediately following the stop-bit sampling tick (1-cycle latency).

Reset
REQ-024 Reset SHALL set the FSM to IDLE and clear all counters and the divider.
REQ-025 Reset SHALL drive rx_data=0x00, rx_ready=0, overrun=0, frame_err=0 and rx_busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no flag set; reception SHALL resume at the next falling edge after reset release.

Verification (OVS_DIV=4, bit period = 64 clk)
REQ-027 Sending 0xA5 with a good stop bit SHALL produce rx_data=0xA5 and rx_ready=1 one cycle after the stop-bit sample, with overrun=0 and frame_err=0.
REQ-028 A 20-cycle low glitch on idle uart_rx SHALL be rejected: the FSM SHALL return to IDLE, rx_busy SHALL pulse, and rx_ready and all flags SHALL stay 0.
REQ-029 Sending 0x3C with the stop bit forced low SHALL set frame_err=1, leave rx_ready=0 and keep rx_data at its prior value; a subsequent rd SHALL clear frame_err.
REQ-030 Sending 0x11 then 0x22 without rd SHALL give rx_data=0x22, rx_ready=1 and overrun=1; rd SHALL then clear both rx_ready and overrun.
REQ-031 rd asserted in the exact cycle 0x55 loads SHALL leave rx_ready=1, rx_data=0x55 and overrun=0.
REQ-032 Reset asserted during bit 4 of a frame SHALL leave all outputs at reset values; a following 0x0F frame SHALL be received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 16x oversampling, holding register and sticky error flags
//   clk       system clock, all state updates on its rising edge
//   reset     asynchronous active-high reset
//   uart_rx   serial line (idle high, LSB first)
//   rd        one-cycle strobe: consumer has taken rx_data (clears rx_ready/overrun/frame_err)
//   rx_data   last good received byte
//   rx_ready  unread byte held in rx_data
//   overrun   sticky: a byte arrived while rx_ready was still set
//   frame_err sticky: a stop bit sampled low
//   rx_busy   receiver FSM is not idle
module uart_receiver #(
  parameter int OVS_DIV = 325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [DW-1:0] div;
  logic          tick;
  logic [3:0]    tcnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  assign tick    = div == DW'(OVS_DIV - 1);
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div <= '0;
    else       div <= tick ? '0 : div + 1'b1;
  end
  // rd clears first; later assignments in the same cycle (byte load, framing error) take precedence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd) begin
        rx_ready  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              tcnt  <= '0;
            end
          end
          START: begin
            if (tcnt == 4'd7) begin
              tcnt  <= '0;
              idx   <= '0;
              state <= rxs ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          DATA: begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              sh[idx] <= rxs;
              idx     <= idx + 3'd1;
              if (idx == 3'd7) state <= STOP;
            end
          end
          STOP: begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              state <= IDLE;
              if (rxs) begin
                rx_data   <= sh;
                rx_ready  <= 1'b1;
                overrun   <= rd ? overrun : (overrun | rx_ready);
                frame_err <= rd ? 1'b0 : frame_err;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
